// File: rtl/mult_err_monitor_if.sv
// Sample-in / report-out bus for mult_err_monitor.
//   in_valid/in_ready  : sample handshake carrying in_a, in_b (operands) and in_r (approx product)
//   out_valid/out_ready: report handshake carrying the window statistics
// The master modport drives samples and consumes reports; the slave modport is the monitor.
interface mult_err_monitor_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SUM_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [15:0]      in_r;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_samples;
  logic [CNT_W-1:0] out_err_cnt;
  logic [SUM_W-1:0] out_sum_abs;
  logic [SUM_W-1:0] out_sum_err;
  logic [15:0]      out_max_abs;
  logic [7:0]       out_max_a;
  logic [7:0]       out_max_b;

  modport master (
    output in_valid, in_a, in_b, in_r, out_ready,
    input  in_ready, out_valid, out_samples, out_err_cnt, out_sum_abs,
           out_sum_err, out_max_abs, out_max_a, out_max_b
  );

  modport slave (
    input  in_valid, in_a, in_b, in_r, out_ready,
    output in_ready, out_valid, out_samples, out_err_cnt, out_sum_abs,
           out_sum_err, out_max_abs, out_max_a, out_max_b
  );
endinterface

// File: rtl/mult_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier.
// Each accepted sample (a, b, r) yields err = r - a*b. Over WINDOW samples it
// accumulates sample count, nonzero-error count, sum |err|, sum err and the
// largest |err| with its operands, then offers one report.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (priority over clear)
//   clear : synchronous abort, drops window and any pending report
//   bus   : mult_err_monitor_if.slave (sample input, report output)
module mult_err_monitor #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SUM_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  mult_err_monitor_if.slave   bus
);

  typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_t           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             s1_valid;
  logic [7:0]       s1_a;
  logic [7:0]       s1_b;
  logic [15:0]      s1_r;
  logic [15:0]      s1_exact;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] sum_abs;
  logic [SUM_W-1:0] sum_err;
  logic [15:0]      max_abs;
  logic [7:0]       max_a;
  logic [7:0]       max_b;

  logic        accept;
  logic        transfer;
  logic [16:0] err;
  logic [15:0] err_abs;

  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    transfer = out_valid_q & bus.out_ready;
    err      = {1'b0, s1_r} - {1'b0, s1_exact};
    // |err| never exceeds 65025, so the low 16 bits of the negation are exact
    err_abs  = err[16] ? 16'(-err) : err[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state       <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_r        <= '0;
      s1_exact    <= '0;
      acc_cnt     <= '0;
      samples     <= '0;
      err_cnt     <= '0;
      sum_abs     <= '0;
      sum_err     <= '0;
      max_abs     <= '0;
      max_a       <= '0;
      max_b       <= '0;
    end else begin
      // Stage 1: capture the sample and its exact product
      s1_valid <= accept;
      if (accept) begin
        s1_a     <= bus.in_a;
        s1_b     <= bus.in_b;
        s1_r     <= bus.in_r;
        s1_exact <= 16'(bus.in_a) * 16'(bus.in_b);
      end

      // Stage 2: fold the previous sample's error into the statistics
      if (s1_valid) begin
        samples <= samples + CNT_W'(1);
        if (err != '0) err_cnt <= err_cnt + CNT_W'(1);
        sum_abs <= sum_abs + SUM_W'(err_abs);
        sum_err <= sum_err + {{(SUM_W-17){err[16]}}, err};
        if (err_abs > max_abs) begin
          max_abs <= err_abs;
          max_a   <= s1_a;
          max_b   <= s1_b;
        end
      end

      case (state)
        ACCUM: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == LAST) begin
              state      <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state       <= REPORT;
          out_valid_q <= 1'b1;
        end
        REPORT: begin
          // No sample is in flight here, so this zeroing never races stage 2
          if (transfer) begin
            state       <= ACCUM;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            acc_cnt     <= '0;
            samples     <= '0;
            err_cnt     <= '0;
            sum_abs     <= '0;
            sum_err     <= '0;
            max_abs     <= '0;
            max_a       <= '0;
            max_b       <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_samples = samples;
  assign bus.out_err_cnt = err_cnt;
  assign bus.out_sum_abs = sum_abs;
  assign bus.out_sum_err = sum_err;
  assign bus.out_max_abs = max_abs;
  assign bus.out_max_a   = max_a;
  assign bus.out_max_b   = max_b;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Directed bench for mult_err_monitor: a WINDOW=4 instance for the main
// scenarios and a WINDOW=1 instance for the per-sample report cadence.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mult_err_monitor;

  logic clk;
  logic rst;
  logic clear;

  int tests;
  int fails;

  mult_err_monitor_if #(.CNT_W(16), .SUM_W(32)) bus4 ();
  mult_err_monitor_if #(.CNT_W(16), .SUM_W(32)) bus1 ();

  mult_err_monitor #(.WINDOW(4), .CNT_W(16), .SUM_W(32)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus4)
  );

  mult_err_monitor #(.WINDOW(1), .CNT_W(16), .SUM_W(32)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample for one cycle on the WINDOW=4 instance.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
    bus4.in_a     = a;
    bus4.in_b     = b;
    bus4.in_r     = r;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
  endtask

  // Consume the pending report.
  task automatic xfer();
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (bus4.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
    tests++; if (bus4.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus4.in_ready); end
    tests++; if (bus1.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_w1: got %b want 1", bus1.in_ready); end
    tests++; if (bus4.out_samples !== 16'd0 || bus4.out_err_cnt !== 16'd0) begin fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus4.out_samples, bus4.out_err_cnt); end
    tests++; if (bus4.out_sum_abs !== 32'd0 || bus4.out_sum_err !== 32'd0) begin fails++; $display("FAIL reset_sums: got %0d/%0d want 0/0", bus4.out_sum_abs, bus4.out_sum_err); end
    tests++; if (bus4.out_max_abs !== 16'd0 || bus4.out_max_a !== 8'd0 || bus4.out_max_b !== 8'd0) begin fails++; $display("FAIL reset_max: got %0d,%0d,%0d want 0,0,0", bus4.out_max_abs, bus4.out_max_a, bus4.out_max_b); end
  endtask

  task automatic test_exact();
    send(8'd3, 8'd5, 16'd15);
    send(8'd255, 8'd255, 16'd65025);
    send(8'd0, 8'd7, 16'd0);
    send(8'd16, 8'd16, 16'd256);
    tests++; if (bus4.out_valid !== 1'b0) begin fails++; $display("FAIL exact_latency_t1: got %b want 0", bus4.out_valid); end
    tests++; if (bus4.in_ready !== 1'b0) begin fails++; $display("FAIL exact_drain_in_ready: got %b want 0", bus4.in_ready); end
    @(negedge clk);
    tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL exact_latency_t2: got %b want 1", bus4.out_valid); end
    tests++; if (bus4.out_samples !== 16'd4) begin fails++; $display("FAIL exact_samples: got %0d want 4", bus4.out_samples); end
    tests++; if (bus4.out_err_cnt !== 16'd0) begin fails++; $display("FAIL exact_err_cnt: got %0d want 0", bus4.out_err_cnt); end
    tests++; if (bus4.out_sum_abs !== 32'd0) begin fails++; $display("FAIL exact_sum_abs: got %0d want 0", bus4.out_sum_abs); end
    tests++; if (bus4.out_sum_err !== 32'd0) begin fails++; $display("FAIL exact_sum_err: got %0d want 0", $signed(bus4.out_sum_err)); end
    tests++; if (bus4.out_max_abs !== 16'd0 || bus4.out_max_a !== 8'd0 || bus4.out_max_b !== 8'd0) begin fails++; $display("FAIL exact_max: got %0d,%0d,%0d want 0,0,0", bus4.out_max_abs, bus4.out_max_a, bus4.out_max_b); end
    xfer();
    tests++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin fails++; $display("FAIL exact_after_xfer: got ov=%b ir=%b want ov=0 ir=1", bus4.out_valid, bus4.in_ready); end
  endtask

  task automatic test_mixed();
    logic [31:0] exp_se;
    exp_se = -32'sd65022;
    send(8'd255, 8'd255, 16'd65024);
    send(8'd10, 8'd10, 16'd104);
    send(8'd2, 8'd3, 16'd6);
    send(8'd255, 8'd255, 16'd0);
    @(negedge clk);
    tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL mixed_out_valid: got %b want 1", bus4.out_valid); end
    tests++; if (bus4.out_samples !== 16'd4) begin fails++; $display("FAIL mixed_samples: got %0d want 4", bus4.out_samples); end
    tests++; if (bus4.out_err_cnt !== 16'd3) begin fails++; $display("FAIL mixed_err_cnt: got %0d want 3", bus4.out_err_cnt); end
    tests++; if (bus4.out_sum_abs !== 32'd65030) begin fails++; $display("FAIL mixed_sum_abs: got %0d want 65030", bus4.out_sum_abs); end
    tests++; if (bus4.out_sum_err !== exp_se) begin fails++; $display("FAIL mixed_sum_err: got %0d want -65022", $signed(bus4.out_sum_err)); end
    tests++; if (bus4.out_max_abs !== 16'd65025 || bus4.out_max_a !== 8'd255 || bus4.out_max_b !== 8'd255) begin fails++; $display("FAIL mixed_max: got %0d,%0d,%0d want 65025,255,255", bus4.out_max_abs, bus4.out_max_a, bus4.out_max_b); end
    xfer();
  endtask

  task automatic test_clear_report_then_tie();
    send(8'd3, 8'd5, 16'd15);
    send(8'd1, 8'd1, 16'd9);
    send(8'd2, 8'd2, 16'd4);
    send(8'd4, 8'd4, 16'd16);
    @(negedge clk);
    tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL clr_rep_pre_valid: got %b want 1", bus4.out_valid); end
    // clear beats out_ready: pending report is discarded
    clear = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus4.out_ready = 1'b0;
    tests++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin fails++; $display("FAIL clr_rep_state: got ov=%b ir=%b want ov=0 ir=1", bus4.out_valid, bus4.in_ready); end
    send(8'd10, 8'd10, 16'd104);
    send(8'd2, 8'd2, 16'd0);
    send(8'd1, 8'd1, 16'd1);
    send(8'd3, 8'd3, 16'd9);
    @(negedge clk);
    tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL tie_out_valid: got %b want 1", bus4.out_valid); end
    tests++; if (bus4.out_samples !== 16'd4 || bus4.out_err_cnt !== 16'd2) begin fails++; $display("FAIL tie_counts: got %0d/%0d want 4/2", bus4.out_samples, bus4.out_err_cnt); end
    tests++; if (bus4.out_sum_abs !== 32'd8 || bus4.out_sum_err !== 32'd0) begin fails++; $display("FAIL tie_sums: got %0d/%0d want 8/0", bus4.out_sum_abs, $signed(bus4.out_sum_err)); end
    tests++; if (bus4.out_max_abs !== 16'd4 || bus4.out_max_a !== 8'd10 || bus4.out_max_b !== 8'd10) begin fails++; $display("FAIL tie_max: got %0d,%0d,%0d want 4,10,10", bus4.out_max_abs, bus4.out_max_a, bus4.out_max_b); end
    xfer();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_se;
    exp_se = -32'sd5;
    send(8'd4, 8'd4, 16'd17);
    send(8'd5, 8'd5, 16'd25);
    send(8'd6, 8'd6, 16'd30);
    send(8'd7, 8'd7, 16'd49);
    @(negedge clk);
    // Offer a sample throughout the stall; it must not be taken
    bus4.in_a = 8'd8; bus4.in_b = 8'd8; bus4.in_r = 16'd0; bus4.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tests++; if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) begin fails++; $display("FAIL bp_hs[%0d]: got ov=%b ir=%b want ov=1 ir=0", i, bus4.out_valid, bus4.in_ready); end
      tests++; if (bus4.out_samples !== 16'd4 || bus4.out_err_cnt !== 16'd2) begin fails++; $display("FAIL bp_counts[%0d]: got %0d/%0d want 4/2", i, bus4.out_samples, bus4.out_err_cnt); end
      tests++; if (bus4.out_sum_abs !== 32'd7 || bus4.out_sum_err !== exp_se) begin fails++; $display("FAIL bp_sums[%0d]: got %0d/%0d want 7/-5", i, bus4.out_sum_abs, $signed(bus4.out_sum_err)); end
      tests++; if (bus4.out_max_abs !== 16'd6 || bus4.out_max_a !== 8'd6 || bus4.out_max_b !== 8'd6) begin fails++; $display("FAIL bp_max[%0d]: got %0d,%0d,%0d want 6,6,6", i, bus4.out_max_abs, bus4.out_max_a, bus4.out_max_b); end
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    xfer();
    tests++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", bus4.out_valid, bus4.in_ready); end
    send(8'd3, 8'd5, 16'd15);
    send(8'd9, 8'd9, 16'd81);
    send(8'd0, 8'd0, 16'd0);
    send(8'd16, 8'd16, 16'd256);
    @(negedge clk);
    tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid: got %b want 1", bus4.out_valid); end
    tests++; if (bus4.out_samples !== 16'd4 || bus4.out_err_cnt !== 16'd0) begin fails++; $display("FAIL bp_next_counts: got %0d/%0d want 4/0", bus4.out_samples, bus4.out_err_cnt); end
    tests++; if (bus4.out_sum_abs !== 32'd0 || bus4.out_max_abs !== 16'd0) begin fails++; $display("FAIL bp_next_stats: got %0d/%0d want 0/0", bus4.out_sum_abs, bus4.out_max_abs); end
    xfer();
  endtask

  task automatic test_clear_mid_window();
    logic [31:0] exp_se;
    exp_se = -32'sd65022;
    send(8'd1, 8'd1, 16'd100);
    send(8'd2, 8'd2, 16'd50);
    clear = 1'b1;
    bus4.in_a = 8'd9; bus4.in_b = 8'd9; bus4.in_r = 16'd0; bus4.in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus4.in_valid = 1'b0;
    tests++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin fails++; $display("FAIL clr_state: got ov=%b ir=%b want ov=0 ir=1", bus4.out_valid, bus4.in_ready); end
    send(8'd255, 8'd255, 16'd65024);
    send(8'd10, 8'd10, 16'd104);
    send(8'd2, 8'd3, 16'd6);
    send(8'd255, 8'd255, 16'd0);
    tests++; if (bus4.out_valid !== 1'b0) begin fails++; $display("FAIL clr_latency_t1: got %b want 0", bus4.out_valid); end
    @(negedge clk);
    tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL clr_latency_t2: got %b want 1", bus4.out_valid); end
    tests++; if (bus4.out_samples !== 16'd4 || bus4.out_err_cnt !== 16'd3) begin fails++; $display("FAIL clr_counts: got %0d/%0d want 4/3", bus4.out_samples, bus4.out_err_cnt); end
    tests++; if (bus4.out_sum_abs !== 32'd65030 || bus4.out_sum_err !== exp_se) begin fails++; $display("FAIL clr_sums: got %0d/%0d want 65030/-65022", bus4.out_sum_abs, $signed(bus4.out_sum_err)); end
    tests++; if (bus4.out_max_abs !== 16'd65025 || bus4.out_max_a !== 8'd255 || bus4.out_max_b !== 8'd255) begin fails++; $display("FAIL clr_max: got %0d,%0d,%0d want 65025,255,255", bus4.out_max_abs, bus4.out_max_a, bus4.out_max_b); end
    xfer();
  endtask

  task automatic test_reset_mid_report();
    send(8'd1, 8'd2, 16'd5);
    send(8'd3, 8'd3, 16'd0);
    send(8'd2, 8'd2, 16'd4);
    send(8'd1, 8'd1, 16'd1);
    @(negedge clk);
    tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL rst_rep_pre_valid: got %b want 1", bus4.out_valid); end
    rst = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    tests++; if (bus4.out_valid !== 1'b0) begin fails++; $display("FAIL rst_rep_valid: got %b want 0", bus4.out_valid); end
    tests++; if (bus4.out_samples !== 16'd0 || bus4.out_err_cnt !== 16'd0) begin fails++; $display("FAIL rst_rep_counts: got %0d/%0d want 0/0", bus4.out_samples, bus4.out_err_cnt); end
    tests++; if (bus4.out_sum_abs !== 32'd0 || bus4.out_sum_err !== 32'd0) begin fails++; $display("FAIL rst_rep_sums: got %0d/%0d want 0/0", bus4.out_sum_abs, bus4.out_sum_err); end
    tests++; if (bus4.out_max_abs !== 16'd0 || bus4.out_max_a !== 8'd0 || bus4.out_max_b !== 8'd0) begin fails++; $display("FAIL rst_rep_max: got %0d,%0d,%0d want 0,0,0", bus4.out_max_abs, bus4.out_max_a, bus4.out_max_b); end
    tests++; if (bus4.in_ready !== 1'b1) begin fails++; $display("FAIL rst_rep_in_ready: got %b want 1", bus4.in_ready); end
  endtask

  task automatic test_window1();
    int reports;
    reports = 0;
    bus1.out_ready = 1'b1;
    bus1.in_a = 8'd3; bus1.in_b = 8'd3; bus1.in_r = 16'd10; bus1.in_valid = 1'b1;
    // Accepts land every third cycle; reports appear on negedges 2, 5 and 8
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 2 || i == 5 || i == 8) begin
        tests++; if (bus1.out_valid !== 1'b1) begin fails++; $display("FAIL w1_valid[%0d]: got %b want 1", i, bus1.out_valid); end
        tests++; if (bus1.out_samples !== 16'd1 || bus1.out_err_cnt !== 16'd1) begin fails++; $display("FAIL w1_counts[%0d]: got %0d/%0d want 1/1", i, bus1.out_samples, bus1.out_err_cnt); end
        tests++; if (bus1.out_sum_abs !== 32'd1 || bus1.out_sum_err !== 32'd1) begin fails++; $display("FAIL w1_sums[%0d]: got %0d/%0d want 1/1", i, bus1.out_sum_abs, bus1.out_sum_err); end
        tests++; if (bus1.out_max_abs !== 16'd1 || bus1.out_max_a !== 8'd3 || bus1.out_max_b !== 8'd3) begin fails++; $display("FAIL w1_max[%0d]: got %0d,%0d,%0d want 1,3,3", i, bus1.out_max_abs, bus1.out_max_a, bus1.out_max_b); end
      end else begin
        tests++; if (bus1.out_valid !== 1'b0) begin fails++; $display("FAIL w1_idle[%0d]: got %b want 0", i, bus1.out_valid); end
      end
      if (bus1.out_valid === 1'b1) reports++;
    end
    bus1.in_valid = 1'b0;
    tests++; if (reports !== 3) begin fails++; $display("FAIL w1_report_count: got %0d want 3", reports); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    clear = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_r = '0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_r = '0; bus1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    test_reset();
    test_exact();
    test_mixed();
    test_clear_report_then_tie();
    test_backpressure();
    test_clear_mid_window();
    test_reset_mid_report();
    test_window1();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_err_monitor.md
Name: mult_err_monitor

Overview:
- Streaming error-statistics stage placed directly downstream of an 8x8 approximate multiplier.
- Per sample, accepts operands A, B and the approximate product R, computes the exact product internally, and forms the error R - A*B.
- Accumulates statistics over a fixed window of samples, then presents one report through a valid/ready handshake.
- Used for on-chip characterisation of approximate multiplier variants.

Parameters:
- WINDOW, 256: samples per report; legal range 1 .. 2^CNT_W-1.
- CNT_W, 16: width of the sample and error counters.
- SUM_W, 32: width of the sums; must be >= 17+clog2(WINDOW) so the sums never overflow.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous abort: drops the current window and restarts accumulation.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input can be accepted.
- in_a  in  8  operand A, unsigned.
- in_b  in  8  operand B, unsigned.
- in_r  in  16  approximate product for in_a, in_b.
- out_valid  out  1  report valid.
- out_ready  in  1  report consumed.
- out_samples  out  CNT_W  samples in the report (equals WINDOW).
- out_err_cnt  out  CNT_W  samples with nonzero error.
- out_sum_abs  out  SUM_W  sum of |error|, unsigned.
- out_sum_err  out  SUM_W  sum of error, two's complement.
- out_max_abs  out  16  largest |error| in the window.
- out_max_a  out  8  in_a of the sample that produced out_max_abs.
- out_max_b  out  8  in_b of the sample that produced out_max_abs.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all accumulators, outputs and stage-1 registers are 0; out_valid=0; state=ACCUM.
  - in_ready=1 from the first cycle with rst low.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Report transfer = out_valid & out_ready.
- Stage 1 (accept cycle): on accept, register in_a, in_b, in_r, exact=in_a*in_b (16-bit unsigned), plus a valid bit. Increment the accepted counter.
- Stage 2, on the cycle after accept:
  - err = {0,r} - {0,exact}, 17-bit signed.
  - abs = |err|, 16 bits.
  - samples += 1.
  - err_cnt += (err != 0).
  - sum_abs += abs.
  - sum_err += sign-extended err.
  - If abs > max_abs (strictly greater): update max_abs, max_a and max_b. On ties the first occurrence is kept.
- State machine:
  - ACCUM: in_ready=1. The accept that brings the accepted count to WINDOW moves to DRAIN.
  - DRAIN: in_ready=0. The last stage-2 update completes this cycle. Moves to REPORT.
  - REPORT: in_ready=0, out_valid=1, out_* stable. On transfer, clear all accumulators and the accepted counter, set out_valid=0 and go to ACCUM. in_ready=1 the next cycle.
- Latency: last accept in cycle t → out_valid=1 in cycle t+2. Minimum window period is WINDOW+2 cycles when out_ready is held at 1.
- out_* values are undefined-but-stable whenever out_valid=0. They are driven from the accumulators, so they show running values; the bench checks them only when out_valid=1.
- clear, in any state:
  - Takes priority over in_valid and out_ready in the same cycle; that sample is not accepted and a pending report is discarded.
  - Next cycle: state=ACCUM, everything zeroed, stage-1 valid=0.
- rst takes priority over clear. Reset mid-REPORT drops the report.
- WINDOW=1: each accept goes ACCUM→DRAIN→REPORT.
- in_valid low while in ACCUM: nothing changes. There is no timeout.

Test Plan (WINDOW=4 unless noted):
- Exact feed: (3,5,15), (255,255,65025), (0,7,0), (16,16,256) → single report with samples=4, err_cnt=0, sum_abs=0, sum_err=0, max_abs=0, max_a=0, max_b=0; out_valid rises exactly 2 cycles after the 4th accept.
- Mixed errors: (255,255,65024), (10,10,104), (2,3,6), (255,255,0) → err_cnt=3, sum_abs=1+4+65025=65030, sum_err=-1+4-65025=-65022, max_abs=65025, max_a=255, max_b=255.
- Tie: errors +4 at (10,10,104) then -4 at (2,2,0), then two exact samples → max_abs=4, max_a=10, max_b=10 (first occurrence kept).
- Backpressure: hold out_ready=0 for 10 cycles during REPORT → in_ready=0 and out_* stable throughout. Release → in_ready=1 the next cycle, and the next report contains only new samples.
- clear asserted with in_valid=1 after 2 accepts → that sample is not counted. The 4 subsequent accepts yield samples=4 with statistics from those 4 only.
- rst asserted while out_valid=1 → out_valid=0 the next cycle, all outputs 0, in_ready=1 once rst is low. Also run a WINDOW=1 instance: a report follows every accept, 3 cycles per sample with out_ready=1.
